// File: rtl/stall_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: tracks E/M destination
// shadows and their remaining latency, plus the HI/LO multiply/divide busy counter.
module stall_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       D_valid,
  input  logic [4:0] D_rs,
  input  logic [4:0] D_rt,
  input  logic [1:0] D_Tuse_rs,
  input  logic [1:0] D_Tuse_rt,
  input  logic [4:0] D_dst,
  input  logic [1:0] D_Tnew,
  input  logic       D_md_start,
  input  logic       D_md_div,
  input  logic       D_md_use,
  output logic       stall,
  output logic       PC_en,
  output logic       FD_en,
  output logic       DE_clr,
  output logic       md_busy,
  output logic [4:0] E_dst,
  output logic [4:0] M_dst,
  output logic [1:0] E_Tnew,
  output logic [1:0] M_Tnew
);

  logic [3:0] md_cnt;
  logic       stall_rs;
  logic       stall_rt;
  logic       stall_md;

  // Register 0 is never a real dependency, so dst 0 in a shadow can never match.
  always_comb begin
    stall_rs = 1'b0;
    stall_rt = 1'b0;
    if (D_valid && (D_rs != 5'd0)) begin
      stall_rs = ((E_dst == D_rs) && (E_Tnew > D_Tuse_rs)) ||
                 ((M_dst == D_rs) && (M_Tnew > D_Tuse_rs));
    end
    if (D_valid && (D_rt != 5'd0)) begin
      stall_rt = ((E_dst == D_rt) && (E_Tnew > D_Tuse_rt)) ||
                 ((M_dst == D_rt) && (M_Tnew > D_Tuse_rt));
    end
  end

  always_comb begin
    md_busy  = (md_cnt != '0);
    stall_md = D_valid && D_md_use && md_busy;
    stall    = stall_rs | stall_rt | stall_md;
    PC_en    = !stall;
    FD_en    = !stall;
    DE_clr   = stall;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_dst  <= '0;
      E_Tnew <= '0;
      M_dst  <= '0;
      M_Tnew <= '0;
    end else begin
      if (stall || !D_valid) begin
        E_dst  <= '0;
        E_Tnew <= '0;
      end else begin
        E_dst  <= D_dst;
        E_Tnew <= D_Tnew;
      end
      M_dst  <= E_dst;
      M_Tnew <= (E_Tnew == '0) ? '0 : E_Tnew - 2'd1;
    end
  end

  // A start held in D by a stall is not accepted; the running count keeps draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (D_valid && D_md_start && !stall) begin
      md_cnt <= D_md_div ? 4'(DIV_LAT) : 4'(MULT_LAT);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_stall_ctrl.sv
// Randomized + directed bench for stall_ctrl: a driver pushes expected outputs from
// an issue-history reference model into a queue, a monitor pops and compares.
module tb_stall_ctrl;

  localparam int unsigned MULT_LAT = 5;
  localparam int unsigned DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       D_valid = 1'b0;
  logic [4:0] D_rs = '0, D_rt = '0, D_dst = '0;
  logic [1:0] D_Tuse_rs = 2'd3, D_Tuse_rt = 2'd3, D_Tnew = '0;
  logic       D_md_start = 1'b0, D_md_div = 1'b0, D_md_use = 1'b0;
  logic       stall, PC_en, FD_en, DE_clr, md_busy;
  logic [4:0] E_dst, M_dst;
  logic [1:0] E_Tnew, M_Tnew;

  stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .D_valid(D_valid), .D_rs(D_rs), .D_rt(D_rt),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt), .D_dst(D_dst), .D_Tnew(D_Tnew),
    .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
    .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_clr(DE_clr), .md_busy(md_busy),
    .E_dst(E_dst), .M_dst(M_dst), .E_Tnew(E_Tnew), .M_Tnew(M_Tnew)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       md_busy;
    logic [4:0] e_dst;
    logic [4:0] m_dst;
    logic [1:0] e_tnew;
    logic [1:0] m_tnew;
  } exp_t;

  // One record per instruction that left D: the cycle it sat in D, its dst and Tnew.
  typedef struct {
    int         cyc;
    logic [4:0] dst;
    logic [1:0] tnew;
  } issue_t;

  exp_t   sb[$];
  issue_t hist[$];
  int     now = 0;
  int     md_acc = -1000;
  int     md_lat = 0;
  int     checks = 0;
  int     errors = 0;

  bit         pend_accept = 1'b0;
  bit         pend_md = 1'b0;
  bit         pend_div = 1'b0;
  logic [4:0] pend_dst = '0;
  logic [1:0] pend_tnew = '0;

  // Producer issued in cycle p has its result forwardable from cycle p+1+Tnew;
  // only producers still in E or M can hold up D.
  function automatic bit hazard(input logic [4:0] r, input logic [1:0] tuse);
    bit h = 1'b0;
    if (r == 5'd0) return 1'b0;
    foreach (hist[i]) begin
      if (hist[i].dst == r && (now - hist[i].cyc) >= 1 && (now - hist[i].cyc) <= 2 &&
          (hist[i].cyc + 1 + int'(hist[i].tnew)) > (now + int'(tuse)))
        h = 1'b1;
    end
    return h;
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] tr, input logic [1:0] tt,
                      input logic [4:0] dst, input logic [1:0] tn,
                      input logic st, input logic dv, input logic us, input bit rst_mid);
    exp_t e;
    bit   busy;
    @(posedge clk);
    #1;
    now++;
    if (!reset && pend_accept) begin
      hist.push_back('{cyc: now - 1, dst: pend_dst, tnew: pend_tnew});
      if (pend_md) begin
        md_acc = now - 1;
        md_lat = pend_div ? int'(DIV_LAT) : int'(MULT_LAT);
      end
    end
    reset = 1'b0;
    while (hist.size() > 0 && (now - hist[0].cyc) > 2) void'(hist.pop_front());

    D_valid = v; D_rs = rs; D_rt = rt; D_Tuse_rs = tr; D_Tuse_rt = tt;
    D_dst = dst; D_Tnew = tn; D_md_start = st; D_md_div = dv; D_md_use = us;

    if (rst_mid) begin
      #2;
      reset = 1'b1;
      hist.delete();
      md_acc = -1000;
    end

    e = '{stall: 1'b0, md_busy: 1'b0, e_dst: '0, m_dst: '0, e_tnew: '0, m_tnew: '0};
    foreach (hist[i]) begin
      if (hist[i].cyc == now - 1) begin
        e.e_dst = hist[i].dst; e.e_tnew = hist[i].tnew;
      end
      if (hist[i].cyc == now - 2) begin
        e.m_dst = hist[i].dst; e.m_tnew = (hist[i].tnew > 0) ? hist[i].tnew - 2'd1 : 2'd0;
      end
    end
    busy = (now > md_acc) && (now <= md_acc + md_lat);
    e.md_busy = busy;
    e.stall = v && (hazard(rs, tr) || hazard(rt, tt) || (us && busy));
    sb.push_back(e);

    pend_accept = v && !e.stall;
    pend_md     = st;
    pend_div    = dv;
    pend_dst    = dst;
    pend_tnew   = tn;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 2'd3, 2'd3, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, expv, now, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("stall",   int'(stall),   int'(e.stall));
        chk("PC_en",   int'(PC_en),   int'(!e.stall));
        chk("FD_en",   int'(FD_en),   int'(!e.stall));
        chk("DE_clr",  int'(DE_clr),  int'(e.stall));
        chk("md_busy", int'(md_busy), int'(e.md_busy));
        chk("E_dst",   int'(E_dst),   int'(e.e_dst));
        chk("M_dst",   int'(M_dst),   int'(e.m_dst));
        chk("E_Tnew",  int'(E_Tnew),  int'(e.e_tnew));
        chk("M_Tnew",  int'(M_Tnew),  int'(e.m_tnew));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic       v, st, dv, us;
    logic [4:0] rs, rt, dst;
    logic [1:0] tr, tt, tn;

    // reset values while reset is still asserted
    step(1'b0, '0, '0, 2'd3, 2'd3, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    nops(2);

    // load-use: lw $8 then addu rs=8 (Tuse 1), held in D across the stall
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 0, 0, 0, 0);
    repeat (3) step(1, 5'd8, 5'd0, 2'd1, 2'd3, 5'd10, 2'd1, 0, 0, 0, 0);
    nops(3);

    // branch after ALU result, then branch after load
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd1, 0, 0, 0, 0);
    repeat (2) step(1, 5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0);
    nops(3);
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd9, 2'd2, 0, 0, 0, 0);
    repeat (3) step(1, 5'd9, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 0, 0, 0, 0);
    nops(3);

    // $0 destination and unused operand
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd2, 0, 0, 0, 0);
    step(1, 5'd0, 5'd0, 2'd0, 2'd0, 5'd4, 2'd1, 0, 0, 0, 0);
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 0, 0, 0, 0);
    step(1, 5'd0, 5'd8, 2'd3, 2'd3, 5'd0, 2'd1, 0, 0, 0, 0);
    nops(3);

    // mult then adjacent mfhi; div then mflo; free issue of non-md while busy
    step(1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1, 0, 1, 0);
    repeat (7) step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 0, 0, 1, 0);
    step(1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1, 1, 1, 0);
    repeat (12) step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 0, 0, 1, 0);
    step(1, 5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1, 0, 1, 0);
    repeat (4) step(1, 5'd5, 5'd6, 2'd1, 2'd1, 5'd7, 2'd1, 0, 0, 0, 0);
    nops(3);

    // div held in D behind a load-use stall, then mflo waits out the full count
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 2'd2, 0, 0, 0, 0);
    repeat (2) step(1, 5'd8, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 1, 1, 1, 0);
    repeat (12) step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd3, 2'd1, 0, 0, 1, 0);
    nops(2);

    // asynchronous reset mid-cycle with md_cnt=7 and E_Tnew=2
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 1, 1, 1, 0);
    nops(2);
    step(1, 5'd0, 5'd0, 2'd3, 2'd3, 5'd12, 2'd2, 0, 0, 0, 0);
    step(1, 5'd12, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 1);
    step(1, 5'd12, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 0, 0, 1, 0);
    nops(2);

    // randomized traffic over a small register set to make hazards frequent
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 7) != 0);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      tr  = 2'($urandom_range(0, 3));
      tt  = 2'($urandom_range(0, 3));
      dst = 5'($urandom_range(0, 3));
      tn  = 2'($urandom_range(0, 2));
      st  = ($urandom_range(0, 15) == 0);
      dv  = 1'($urandom_range(0, 1));
      us  = st || ($urandom_range(0, 7) == 0);
      step(v, rs, rt, tr, tt, dst, tn, st, dv, us, ($urandom_range(0, 499) == 0));
    end

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
